alu_seq_unit: RTL and testbench



---
 rtl/alu_seq_unit.sv | 133 +++++++++++++
 tb/tb_alu_seq_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
// Handshaked ALU execution unit: single-cycle arith/shift/compare/logic ops,
// iterative 8-step shift-add multiply, one outstanding command at a time.
module alu_seq_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_s,
    input  logic [1:0]  req_m,
    input  logic [7:0]  req_x,
    input  logic [7:0]  req_y,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_z,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] rsp_z_q, rsp_z_d;
    logic [15:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic        accept;
    logic        is_mul;
    logic [15:0] partial;

    function automatic logic [15:0] alu_result(input logic [1:0] s, input logic [1:0] m,
                                               input logic [7:0] x, input logic [7:0] y);
        logic [15:0] z;
        z = 16'd0;
        case (s)
            2'b00: begin
                case (m)
                    2'b00:   z = {8'd0, x} + {8'd0, y};
                    2'b01:   z = {8'd0, x} - {8'd0, y};
                    2'b11:   z = {8'd0, x} + 16'd1;
                    default: z = 16'd0; // multiply goes through the iterative path
                endcase
            end
            2'b01: begin
                case (m)
                    2'b00:   z = {8'd0, x[6:0], 1'b0};
                    2'b01:   z = {8'd0, 1'b1, x[7:1]};
                    2'b10:   z = {8'd0, x[6:0], x[7]};
                    default: z = {8'd0, x[0], x[7:1]};
                endcase
            end
            2'b10: z = {13'd0, (x > y), (x == y), (x < y)};
            default: begin
                case (m)
                    2'b00:   z = {8'd0, x & y};
                    2'b01:   z = {8'd0, x | y};
                    2'b10:   z = {8'd0, ~x};
                    default: z = {8'd0, x ^ y};
                endcase
            end
        endcase
        return z;
    endfunction

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign rsp_z     = rsp_z_q;
    assign accept    = req_valid & req_ready;
    assign is_mul    = (req_s == 2'b00) && (req_m == 2'b10);
    assign partial   = y_q[cnt_q] ? ({8'd0, x_q} << cnt_q) : 16'd0;

    always_comb begin
        state_d = state_q;
        rsp_z_d = rsp_z_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    x_d = req_x;
                    y_d = req_y;
                    if (is_mul) begin
                        acc_d   = 16'd0;
                        cnt_d   = 3'd0;
                        state_d = MUL;
                    end else begin
                        rsp_z_d = alu_result(req_s, req_m, req_x, req_y);
                        state_d = DONE;
                    end
                end
            end
            MUL: begin
                acc_d = acc_q + partial;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    rsp_z_d = acc_q + partial;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rsp_z_q <= 16'd0;
        end else begin
            state_q <= state_d;
            rsp_z_q <= rsp_z_d;
        end
    end

    // Operand and multiply working registers are only meaningful after an accept.
    always_ff @(posedge clk) begin
        acc_q <= acc_d;
        cnt_q <= cnt_d;
        x_q   <= x_d;
        y_q   <= y_d;
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit: table of ops with expected result/latency,
// plus backpressure and reset-mid-multiply sequences.
module tb_alu_seq_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_s;
    logic [1:0]  req_m;
    logic [7:0]  req_x;
    logic [7:0]  req_y;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_z;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  s;
        logic [1:0]  m;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] z;
        int          lat;
    } vec_t;

    vec_t vecs[19];

    alu_seq_unit dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_s     (req_s),
        .req_m     (req_m),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command with rsp_ready high, measure edges from accept to rsp_valid.
    task automatic run_op(input string name, input vec_t v);
        int lat;
        bit ready_seen;
        req_s     = v.s;
        req_m     = v.m;
        req_x     = v.x;
        req_y     = v.y;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        req_x     = ~v.x;
        req_y     = ~v.y;
        req_s     = ~v.s;
        check({name, "_busy"}, {31'd0, busy}, 32'd1);
        lat = 0;
        ready_seen = 1'b0;
        while (!rsp_valid && lat < 20) begin
            if (req_ready) ready_seen = 1'b1;
            tick();
            lat++;
        end
        check({name, "_lat"}, lat, v.lat);
        check({name, "_z"}, {16'd0, rsp_z}, {16'd0, v.z});
        check({name, "_rdy_low"}, {31'd0, ready_seen | req_ready}, 32'd0);
        tick();
        check({name, "_release"}, {30'd0, rsp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        vecs[0]  = '{2'b00, 2'b00, 8'd100, 8'd12,  16'h0070, 0};
        vecs[1]  = '{2'b00, 2'b01, 8'd10,  8'd20,  16'hFFF6, 0};
        vecs[2]  = '{2'b00, 2'b11, 8'd255, 8'd0,   16'h0100, 0};
        vecs[3]  = '{2'b00, 2'b10, 8'd3,   8'd5,   16'h000F, 8};
        vecs[4]  = '{2'b00, 2'b10, 8'd255, 8'd255, 16'hFE01, 8};
        vecs[5]  = '{2'b01, 2'b01, 8'hFF,  8'h00,  16'h00FF, 0};
        vecs[6]  = '{2'b01, 2'b10, 8'hF0,  8'h00,  16'h00E1, 0};
        vecs[7]  = '{2'b01, 2'b11, 8'h0F,  8'h00,  16'h0087, 0};
        vecs[8]  = '{2'b11, 2'b10, 8'hCC,  8'h00,  16'h0033, 0};
        vecs[9]  = '{2'b11, 2'b11, 8'hCC,  8'hAA,  16'h0066, 0};
        vecs[10] = '{2'b10, 2'b00, 8'd144, 8'd88,  16'h0004, 0};
        vecs[11] = '{2'b10, 2'b00, 8'd88,  8'd88,  16'h0002, 0};
        vecs[12] = '{2'b10, 2'b00, 8'd0,   8'd1,   16'h0001, 0};
        vecs[13] = '{2'b00, 2'b00, 8'd200, 8'd100, 16'h012C, 0};
        vecs[14] = '{2'b01, 2'b00, 8'h81,  8'h00,  16'h0002, 0};
        vecs[15] = '{2'b11, 2'b00, 8'hF0,  8'h3C,  16'h0030, 0};
        vecs[16] = '{2'b11, 2'b01, 8'hF0,  8'h0F,  16'h00FF, 0};
        vecs[17] = '{2'b10, 2'b11, 8'd5,   8'd3,   16'h0004, 0};
        vecs[18] = '{2'b00, 2'b10, 8'd0,   8'd200, 16'h0000, 8};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_s     = 2'b00;
        req_m     = 2'b00;
        req_x     = 8'h00;
        req_y     = 8'h00;
        rsp_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_z", {16'd0, rsp_z}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        tick();

        for (int i = 0; i < 19; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: result must hold while rsp_ready is low; a pending request waits.
        rsp_ready = 1'b0;
        req_s = 2'b00; req_m = 2'b00; req_x = 8'd55; req_y = 8'd45;
        req_valid = 1'b1;
        tick();
        req_s = 2'b11; req_m = 2'b01; req_x = 8'h11; req_y = 8'h22;
        check("bp_first_valid", {31'd0, rsp_valid}, 32'd1);
        check("bp_first_z", {16'd0, rsp_z}, 32'h0064);
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("bp_hold%0d", c), {14'd0, rsp_valid, req_ready, rsp_z}, {14'd0, 2'b10, 16'h0064});
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_handshake", {14'd0, rsp_valid, req_ready, rsp_z}, {14'd0, 2'b01, 16'h0064});
        tick();
        req_valid = 1'b0;
        check("bp_second_valid", {31'd0, rsp_valid}, 32'd1);
        check("bp_second_z", {16'd0, rsp_z}, 32'h0033);
        tick();
        check("bp_second_release", {31'd0, rsp_valid}, 32'd0);

        // Reset in the middle of a multiply discards it.
        req_s = 2'b00; req_m = 2'b10; req_x = 8'd200; req_y = 8'd200;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        check("mulrst_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mulrst_valid", {31'd0, rsp_valid}, 32'd0);
        check("mulrst_z", {16'd0, rsp_z}, 32'd0);
        check("mulrst_busy", {31'd0, busy}, 32'd0);
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (rsp_valid) seen++;
            tick();
        end
        check("mulrst_no_rsp", seen, 0);
        run_op("after_rst_add", '{2'b00, 2'b00, 8'd1, 8'd1, 16'h0002, 0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
